scope_rle: RTL and testbench

Run-length compression front end placed directly upstream of `wbscope`. It accepts a raw 31-bit sample stream with a trigger and emits at most one 32-bit word per accepted sample. Runs of identical samples collapse into a raw word plus a count word, so a fixed-depth scope buffer covers far more time. Outputs connect straight to the scope's `i_ce`, `i_trigger` and `i_data` inputs.

---
 rtl/scope_rle_pkg.sv | 19 +
 rtl/scope_rle.sv | 110 +++++++++++
 tb/tb_scope_rle.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/scope_rle_pkg.sv
// Shared encoding definitions for the scope run-length front end.
// The scope decompression software and the bench decode words with these same values.
package scope_rle_pkg;

    // Value of the flag bit (bit DW of each output word).
    typedef enum logic {
        KIND_RAW = 1'b0,
        KIND_RUN = 1'b1
    } word_kind_e;

    // Which word, if any, the current accepted sample produces.
    typedef enum logic [1:0] {
        EMIT_NONE,
        EMIT_RAW,
        EMIT_RUN_COUNT,
        EMIT_RUN_MAX
    } emit_sel_e;

endpackage

// File: rtl/scope_rle.sv
// Run-length compression front end for wbscope: raw word per segment plus run-count words.
// Outputs are registered and feed the scope's i_ce / i_trigger / i_data directly.
module scope_rle
    import scope_rle_pkg::*;
#(
    parameter int             DW     = 31,
    // Largest count one run word carries; must be at least 2.
    parameter logic [DW-1:0]  MAXRUN = {DW{1'b1}}
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_ce,
    input  logic          i_trigger,
    input  logic [DW-1:0] i_data,
    output logic          o_ce,
    output logic          o_trigger,
    output logic [DW:0]   o_data
);

    localparam int FLAG_BIT = DW;

    logic [DW-1:0] r_prev;
    logic          r_pend;
    logic          r_ptrig;
    logic [DW-1:0] r_count;
    logic          r_primed;

    logic          new_seg;
    logic [DW:0]   count_inc;
    logic          at_max;
    emit_sel_e     emit_sel;
    logic [DW:0]   emit_word;
    logic          emit_trig;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        new_seg   = !r_primed || (i_data != r_prev) || i_trigger;
        count_inc = {1'b0, r_count} + {{DW{1'b0}}, 1'b1};
        at_max    = (count_inc == {1'b0, MAXRUN});
        emit_sel  = EMIT_NONE;

        if (i_ce) begin
            if (r_pend)
                emit_sel = EMIT_RAW;
            else if (new_seg && (r_count != '0))
                emit_sel = EMIT_RUN_COUNT;
            else if (!new_seg && at_max)
                emit_sel = EMIT_RUN_MAX;
        end
    end

    always_comb begin
        emit_word = '0;
        emit_trig = 1'b0;
        unique case (emit_sel)
            EMIT_RAW: begin
                emit_word = {KIND_RAW, r_prev};
                emit_trig = r_ptrig;
            end
            EMIT_RUN_COUNT: emit_word = {KIND_RUN, r_count};
            EMIT_RUN_MAX:   emit_word = {KIND_RUN, MAXRUN};
            default:        emit_word = '0;
        endcase
    end

    // Segment tracking. A triggering sample always opens a fresh segment so its
    // raw word carries the trigger and is never hidden inside a run count.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev   <= '0;
            r_pend   <= 1'b0;
            r_ptrig  <= 1'b0;
            r_count  <= '0;
            r_primed <= 1'b0;
        end else if (i_ce) begin
            r_primed <= 1'b1;
            if (new_seg) begin
                r_prev  <= i_data;
                r_pend  <= 1'b1;
                r_ptrig <= i_trigger;
                r_count <= '0;
            end else begin
                // The pending raw word went out this cycle via EMIT_RAW.
                r_pend  <= 1'b0;
                r_ptrig <= 1'b0;
                r_count <= at_max ? '0 : count_inc[DW-1:0];
            end
        end
    end

    // Registered output stage; one word at most per accepted sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ce      <= 1'b0;
            o_trigger <= 1'b0;
            o_data    <= '0;
        end else begin
            o_ce      <= (emit_sel != EMIT_NONE);
            o_trigger <= emit_trig;
            if (emit_sel != EMIT_NONE)
                o_data <= emit_word;
        end
    end

    // Flag bit position is fixed by the encoding; kept named for readers of the decode side.
    logic unused_flag_pos;
    assign unused_flag_pos = emit_word[FLAG_BIT];

endmodule

// File: tb/tb_scope_rle.sv
// Directed self-checking bench for scope_rle: default build plus a MAXRUN=4 build for saturation.
// Expected words are hand-computed from the segment/run encoding.
module tb_scope_rle;
    import scope_rle_pkg::*;

    localparam int DW = 31;

    logic          clk;
    logic          rst_n;
    logic          ce;
    logic          trig;
    logic [DW-1:0] data;

    logic          d_ce, d_trig;
    logic [DW:0]   d_data;
    logic          s_ce, s_trig;
    logic [DW:0]   s_data;

    int checks = 0;
    int errors = 0;

    scope_rle #(.DW(DW)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_trigger(trig), .i_data(data),
        .o_ce(d_ce), .o_trigger(d_trig), .o_data(d_data)
    );

    scope_rle #(.DW(DW), .MAXRUN(31'd4)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_trigger(trig), .i_data(data),
        .o_ce(s_ce), .o_trigger(s_trig), .o_data(s_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected observation {o_ce, o_trigger, o_data} with data masked to 0 when o_ce is low.
    function automatic logic [33:0] raw_w(input logic [DW-1:0] v, input logic t);
        return {1'b1, t, KIND_RAW, v};
    endfunction

    function automatic logic [33:0] run_w(input logic [DW-1:0] c);
        return {1'b1, 1'b0, KIND_RUN, c};
    endfunction

    function automatic logic [33:0] obs_dut();
        return {d_ce, d_trig, d_ce ? d_data : 32'h0};
    endfunction

    function automatic logic [33:0] obs_sat();
        return {s_ce, s_trig, s_ce ? s_data : 32'h0};
    endfunction

    task automatic apply_reset();
        ce    = 1'b0;
        trig  = 1'b0;
        data  = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic accept(input logic [DW-1:0] v, input logic t);
        @(negedge clk);
        ce   = 1'b1;
        data = v;
        trig = t;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        ce   = 1'b0;
        trig = 1'b1;
        data = 31'h5A5A_5A5;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ce    = 1'b1;
        trig  = 1'b1;
        data  = 31'd77;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({d_ce, d_trig, d_data} !== 34'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {d_ce, d_trig, d_data});
        end
        apply_reset();
    endtask

    task automatic test_distinct();
        logic [DW-1:0] vin [4] = '{31'd5, 31'd6, 31'd7, 31'd8};
        logic [33:0]   exp [4];
        exp = '{34'h0, raw_w(31'd5, 1'b0), raw_w(31'd6, 1'b0), raw_w(31'd7, 1'b0)};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            accept(vin[i], 1'b0);
            checks++;
            if (obs_dut() !== exp[i]) begin
                errors++;
                $display("FAIL distinct[%0d]: got %h expected %h", i, obs_dut(), exp[i]);
            end
        end
    endtask

    task automatic test_simple_run();
        logic [DW-1:0] vin [6] = '{31'd9, 31'd9, 31'd9, 31'd9, 31'd3, 31'd4};
        logic [33:0]   exp [6];
        exp = '{34'h0, raw_w(31'd9, 1'b0), 34'h0, 34'h0, run_w(31'd3), raw_w(31'd3, 1'b0)};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            accept(vin[i], 1'b0);
            checks++;
            if (obs_dut() !== exp[i]) begin
                errors++;
                $display("FAIL simple_run[%0d]: got %h expected %h", i, obs_dut(), exp[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [DW-1:0] vin [12];
        logic [33:0]   exp [12];
        for (int i = 0; i < 12; i++) begin
            vin[i] = (i < 10) ? 31'd1 : 31'd2;
            exp[i] = 34'h0;
        end
        exp[1]  = raw_w(31'd1, 1'b0);
        exp[4]  = run_w(31'd4);
        exp[8]  = run_w(31'd4);
        exp[10] = run_w(31'd1);
        exp[11] = raw_w(31'd2, 1'b0);
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            accept(vin[i], 1'b0);
            checks++;
            if (obs_sat() !== exp[i]) begin
                errors++;
                $display("FAIL saturation[%0d]: got %h expected %h", i, obs_sat(), exp[i]);
            end
        end
    endtask

    task automatic test_trigger_in_run();
        logic          tin [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [33:0]   exp [4];
        exp = '{34'h0, raw_w(31'd7, 1'b0), run_w(31'd1), raw_w(31'd7, 1'b1)};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            accept(31'd7, tin[i]);
            checks++;
            if (obs_dut() !== exp[i]) begin
                errors++;
                $display("FAIL trigger_in_run[%0d]: got %h expected %h", i, obs_dut(), exp[i]);
            end
        end
    endtask

    task automatic test_sparse_ce();
        logic [DW-1:0] vin  [6] = '{31'd2, 31'd2, 31'd2, 31'd2, 31'd2, 31'd6};
        int            gaps [6] = '{1, 0, 3, 2, 1, 0};
        logic [33:0]   exp  [6];
        exp = '{34'h0, raw_w(31'd2, 1'b0), 34'h0, 34'h0, 34'h0, run_w(31'd4)};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            accept(vin[i], 1'b0);
            checks++;
            if (obs_dut() !== exp[i]) begin
                errors++;
                $display("FAIL sparse[%0d]: got %h expected %h", i, obs_dut(), exp[i]);
            end
            for (int g = 0; g < gaps[i]; g++) begin
                idle_cycle();
                checks++;
                if (d_ce !== 1'b0 || d_trig !== 1'b0) begin
                    errors++;
                    $display("FAIL sparse_idle[%0d.%0d]: got ce=%b trig=%b expected 0", i, g, d_ce, d_trig);
                end
            end
        end
    endtask

    task automatic test_mid_run_reset();
        logic [DW-1:0] vin [3] = '{31'd9, 31'd9, 31'd5};
        logic [33:0]   exp [3];
        exp = '{34'h0, raw_w(31'd9, 1'b0), run_w(31'd1)};
        apply_reset();
        accept(31'd9, 1'b0);
        accept(31'd9, 1'b0);
        checks++;
        if (obs_dut() !== raw_w(31'd9, 1'b0)) begin
            errors++;
            $display("FAIL pre_reset_raw: got %h expected %h", obs_dut(), raw_w(31'd9, 1'b0));
        end
        accept(31'd9, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({d_ce, d_trig, d_data} !== 34'h0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h expected 0", {d_ce, d_trig, d_data});
        end
        ce = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            accept(vin[i], 1'b0);
            checks++;
            if (obs_dut() !== exp[i]) begin
                errors++;
                $display("FAIL post_reset[%0d]: got %h expected %h", i, obs_dut(), exp[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ce    = 1'b0;
        trig  = 1'b0;
        data  = '0;
        test_reset();
        test_distinct();
        test_simple_run();
        test_saturation();
        test_trigger_in_run();
        test_sparse_ce();
        test_mid_run_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
